// File: rtl/text_vmem.sv
// text_vmem -- character-cell video memory for a scrolling text terminal.
//
// Keys arrive on a valid/ready handshake and are placed at a cursor that
// advances, wraps and scrolls like a teletype. The VGA side reads
// characters by logical (x,y) position and receives the glyph row/column
// offsets that go with the current pixel.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   key_in, p_valid     ASCII key and its valid strobe
//   p_ready             high only while the block can accept a key
//   x, y                display-side character column / logical line
//   h_addr, v_addr      VGA pixel column / line
//   ascii_out           registered character at (x,y)
//   row, col            registered glyph row / column inside the cell
//   cur_x, cur_y        current logical cursor position
//
// Optional build macro TEXT_VMEM_CURSOR_EN: adds a blinking underscore
// cursor that replaces the character at the cursor position on alternate
// BLINK_CYCLES-long phases. Without it ascii_out is always memory data.

module text_vmem #(
  parameter int COLS         = 70,
  parameter int ROWS         = 30,
  parameter int CHAR_W       = 9,
  parameter int CHAR_H       = 16,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              key_in,
  input  logic                    p_valid,
  output logic                    p_ready,
  input  logic [$clog2(COLS)-1:0] x,
  input  logic [$clog2(ROWS)-1:0] y,
  input  logic [9:0]              h_addr,
  input  logic [9:0]              v_addr,
  output logic [7:0]              ascii_out,
  output logic [3:0]              row,
  output logic [3:0]              col,
  output logic [$clog2(COLS)-1:0] cur_x,
  output logic [$clog2(ROWS)-1:0] cur_y
);

  localparam int XW    = $clog2(COLS);
  localparam int YW    = $clog2(ROWS);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = $clog2(CELLS);

  localparam logic [XW:0] COLS_L = (XW+1)'(COLS);
  localparam logic [YW:0] ROWS_L = (YW+1)'(ROWS);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SCROLL
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   cnt, cnt_n;
  logic [XW-1:0]   cur_x_n;
  logic [YW-1:0]   cur_y_n;
  logic [YW-1:0]   top, top_n;
  logic            adv;

  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      wdata;

  logic [7:0]      mem [CELLS];

  logic [AW-1:0]   rd_addr;
  logic            rd_valid;
  logic [9:0]      x_px, y_px;
  logic [9:0]      col_diff, row_diff;
  logic            unused_px_hi;

  // Logical line y is stored at physical line (y + top) mod ROWS, so a
  // scroll only bumps top instead of moving every character.
  function automatic logic [AW-1:0] phys_addr(input logic [XW-1:0] cx,
                                              input logic [YW-1:0] cy,
                                              input logic [YW-1:0] t);
    logic [YW:0]   sum;
    logic [YW-1:0] prow;
    sum = {1'b0, cy} + {1'b0, t};
    if (sum >= ROWS_L) sum = sum - ROWS_L;
    prow = sum[YW-1:0];
    return AW'(prow) * AW'(COLS) + AW'(cx);
  endfunction

  assign p_ready = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
      cur_x <= '0;
      cur_y <= '0;
      top   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cur_x <= cur_x_n;
      cur_y <= cur_y_n;
      top   <= top_n;
    end
  end

  // One counter serves both the full-screen clear and the single-line
  // scroll clear; it is always zero when IDLE is entered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_x_n = cur_x;
    cur_y_n = cur_y;
    top_n   = top;
    adv     = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = 8'h00;

    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
        if (cnt == AW'(CELLS - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      IDLE: begin
        if (p_valid) begin
          if (key_in == 8'h0A) begin
            cur_x_n = '0;
            adv     = 1'b1;
          end else if (key_in == 8'h08) begin
            if (cur_x != '0) begin
              cur_x_n = cur_x - 1'b1;
              we      = 1'b1;
              waddr   = phys_addr(cur_x - 1'b1, cur_y, top);
            end else if (cur_y != '0) begin
              cur_x_n = XW'(COLS - 1);
              cur_y_n = cur_y - 1'b1;
              we      = 1'b1;
              waddr   = phys_addr(XW'(COLS - 1), cur_y - 1'b1, top);
            end
          end else begin
            we    = 1'b1;
            waddr = phys_addr(cur_x, cur_y, top);
            wdata = key_in;
            if (cur_x == XW'(COLS - 1)) begin
              cur_x_n = '0;
              adv     = 1'b1;
            end else begin
              cur_x_n = cur_x + 1'b1;
            end
          end

          // At the bottom line the cursor stays put and the window moves.
          if (adv) begin
            if (cur_y != YW'(ROWS - 1)) begin
              cur_y_n = cur_y + 1'b1;
            end else begin
              top_n   = (top == YW'(ROWS - 1)) ? '0 : top + 1'b1;
              state_n = SCROLL;
              cnt_n   = '0;
            end
          end
        end
      end

      SCROLL: begin
        // top already holds the new value, so the bottom logical line maps
        // onto the physical line that used to be the top of the screen.
        we    = 1'b1;
        waddr = phys_addr(XW'(cnt), YW'(ROWS - 1), top);
        if (cnt == AW'(COLS - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: state_n = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_valid = ({1'b0, x} < COLS_L) && ({1'b0, y} < ROWS_L);
  assign rd_addr  = phys_addr(x, y, top);
  assign x_px     = 10'(x) * 10'(CHAR_W);
  assign y_px     = 10'(y) * 10'(CHAR_H);
  assign col_diff = h_addr - x_px;
  assign row_diff = v_addr - y_px;

  // Glyph offsets only need the low nibble; the upper bits are dropped.
  assign unused_px_hi = ^{col_diff[9:4], row_diff[9:4]};

`ifdef TEXT_VMEM_CURSOR_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  // Keeps the blink period parameter referenced when the overlay is absent.
  localparam int unused_blink_cycles = BLINK_CYCLES;
`endif

  // The read uses the memory value before any same-edge write lands, so a
  // cell written this cycle reads back its old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ascii_out <= 8'h00;
      row       <= 4'h0;
      col       <= 4'h0;
    end else begin
`ifdef TEXT_VMEM_CURSOR_EN
      if (blink_phase && (x == cur_x) && (y == cur_y))
        ascii_out <= 8'h5F;
      else
        ascii_out <= rd_valid ? mem[rd_addr] : 8'h00;
`else
      ascii_out <= rd_valid ? mem[rd_addr] : 8'h00;
`endif
      row <= row_diff[3:0];
      col <= col_diff[3:0];
    end
  end

endmodule

// File: tb/tb_text_vmem.sv
// tb_text_vmem -- randomized self-checking bench for text_vmem.
// The reference model keeps the screen as a plain 2-D array of logical
// lines and scrolls by shifting lines up, independent of the DUT's
// offset-register scheme.

module tb_text_vmem;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CW    = 9;
  localparam int CH    = 16;
  localparam int BLINK = 4;
`ifdef TEXT_VMEM_CURSOR_EN
  localparam bit CURSOR_EN = 1'b1;
`else
  localparam bit CURSOR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_in;
  logic       p_valid;
  logic       p_ready;
  logic [6:0] x;
  logic [4:0] y;
  logic [9:0] h_addr;
  logic [9:0] v_addr;
  logic [7:0] ascii_out;
  logic [3:0] row;
  logic [3:0] col;
  logic [6:0] cur_x;
  logic [4:0] cur_y;

  text_vmem #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CW), .CHAR_H(CH), .BLINK_CYCLES(BLINK)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .p_valid(p_valid),
    .p_ready(p_ready), .x(x), .y(y), .h_addr(h_addr), .v_addr(v_addr),
    .ascii_out(ascii_out), .row(row), .col(col), .cur_x(cur_x), .cur_y(cur_y)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; drives the expected blink phase.
  int tb_cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  byte unsigned scr [ROWS][COLS];
  int cx, cy;

  task automatic checkOutput(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int expAscii(input int xx, input int yy);
    int phase;
    phase = ((tb_cyc - 1) / BLINK) % 2;
    if (CURSOR_EN && phase == 1 && xx == cx && yy == cy) return 'h5F;
    return int'(scr[yy][xx]);
  endfunction

  task automatic modelClear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
    cx = 0;
    cy = 0;
  endtask

  task automatic modelAdvance(output bit scrolled);
    scrolled = 1'b0;
    if (cy < ROWS - 1) begin
      cy++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
      scrolled = 1'b1;
    end
  endtask

  task automatic modelKey(input byte unsigned k, output bit scrolled);
    scrolled = 1'b0;
    if (k == 8'h0A) begin
      cx = 0;
      modelAdvance(scrolled);
    end else if (k == 8'h08) begin
      if (cx > 0) begin
        cx--;
        scr[cy][cx] = 8'h00;
      end else if (cy > 0) begin
        cx = COLS - 1;
        cy--;
        scr[cy][cx] = 8'h00;
      end
    end else begin
      scr[cy][cx] = k;
      if (cx == COLS - 1) begin
        cx = 0;
        modelAdvance(scrolled);
      end else begin
        cx++;
      end
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic readCell(input int xx, input int yy);
    int hh, vv;
    hh = int'($urandom_range(0, 639));
    vv = int'($urandom_range(0, 479));
    x = 7'(xx);
    y = 5'(yy);
    h_addr = 10'(hh);
    v_addr = 10'(vv);
    @(negedge clk);
    checkOutput($sformatf("ascii(%0d,%0d)", xx, yy), int'(ascii_out), expAscii(xx, yy));
    checkOutput($sformatf("col(%0d,h=%0d)", xx, hh), int'(col), (hh - xx * CW) & 15);
    checkOutput($sformatf("row(%0d,v=%0d)", yy, vv), int'(row), (vv - yy * CH) & 15);
  endtask

  task automatic checkCursor(input string tag);
    checkOutput({tag, "_cur_x"}, int'(cur_x), cx);
    checkOutput({tag, "_cur_y"}, int'(cur_y), cy);
  endtask

  task automatic sweep();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) readCell(c, r);
  endtask

  // Sends one key, then measures how long p_ready stays low while holding
  // a stray key on p_valid that must be ignored.
  task automatic applyStimulus(input byte unsigned k);
    int n;
    bit sc;
    n = 0;
    while (!p_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_before_key", int'(p_ready), 1);
    if (!p_ready) return;
    key_in  = k;
    p_valid = 1'b1;
    @(negedge clk);
    p_valid = 1'b0;
    modelKey(k, sc);
    n = 0;
    while (!p_ready && n < 200) begin
      p_valid = 1'b1;
      key_in  = 8'h58;
      @(negedge clk);
      n++;
    end
    p_valid = 1'b0;
    checkOutput($sformatf("ready_low_after_0x%0h", k), n, sc ? COLS : 0);
  endtask

  task automatic resetAndClear(input string tag);
    int n;
    reset = 1'b1;
    #1;
    checkOutput({tag, "_rst_p_ready"}, int'(p_ready), 0);
    checkOutput({tag, "_rst_ascii"}, int'(ascii_out), 0);
    checkOutput({tag, "_rst_row"}, int'(row), 0);
    checkOutput({tag, "_rst_col"}, int'(col), 0);
    checkOutput({tag, "_rst_cur_x"}, int'(cur_x), 0);
    checkOutput({tag, "_rst_cur_y"}, int'(cur_y), 0);
    @(negedge clk);
    reset = 1'b0;
    modelClear();
    n = 0;
    while (!p_ready && n < 3000) begin
      p_valid = (n < 50);
      key_in  = 8'h51;
      @(negedge clk);
      n++;
    end
    p_valid = 1'b0;
    checkOutput({tag, "_clear_cycles"}, n, ROWS * COLS);
  endtask

  function automatic byte unsigned pickKey();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 10) return 8'h0A;
    if (r < 22) return 8'h08;
    if (r < 90) return 8'($urandom_range(32, 126));
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    reset   = 1'b1;
    p_valid = 1'b0;
    key_in  = 8'h00;
    x       = '0;
    y       = '0;
    h_addr  = '0;
    v_addr  = '0;

    resetAndClear("init");
    checkCursor("after_clear");
    sweep();

    applyStimulus(8'h41);
    applyStimulus(8'h42);
    readCell(0, 0);
    readCell(1, 0);
    checkOutput("AB_cur_x", int'(cur_x), 2);
    applyStimulus(8'h08);
    readCell(1, 0);
    checkOutput("BS_cur_x", int'(cur_x), 1);

    for (int i = 0; i < 700; i++) begin
      applyStimulus(pickKey());
      if (i % 5 == 0)
        readCell(int'($urandom_range(0, COLS - 1)), int'($urandom_range(0, ROWS - 1)));
      if (i % 50 == 0) checkCursor($sformatf("rand%0d", i));
    end
    sweep();
    checkCursor("after_random");

    resetAndClear("wrap");
    for (int i = 0; i < COLS; i++) applyStimulus(8'h5A);
    checkOutput("wrap_cur_x", int'(cur_x), 0);
    checkOutput("wrap_cur_y", int'(cur_y), 1);
    applyStimulus(8'h5A);
    readCell(0, 1);
    applyStimulus(8'h08);
    applyStimulus(8'h08);
    applyStimulus(8'h08);
    checkOutput("bs_up_cur_x", int'(cur_x), 68);
    checkOutput("bs_up_cur_y", int'(cur_y), 0);
    readCell(69, 0);
    readCell(68, 0);

    while (cy < ROWS - 1) begin
      applyStimulus(8'(8'h61 + cy));
      applyStimulus(8'(8'h41 + cy));
      applyStimulus(8'h0A);
    end
    applyStimulus(8'h0A);
    checkCursor("first_scroll");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(8'($urandom_range(33, 126)));
      applyStimulus(8'($urandom_range(33, 126)));
      applyStimulus(8'h0A);
    end
    sweep();
    checkCursor("after_scrolls");

    x = 7'd0;
    y = 5'd0;
    key_in  = 8'h0A;
    p_valid = 1'b1;
    @(negedge clk);
    p_valid = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("mid_scroll_ready", int'(p_ready), 0);
    #2;
    resetAndClear("mid_scroll");
    checkCursor("after_mid_scroll_reset");
    sweep();

    applyStimulus(8'h48);
    applyStimulus(8'h49);
    for (int i = 0; i < 16; i++) readCell(cx, cy);
    readCell(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/text_vmem.md
TEXT_VMEM -- requirements
Module: text_vmem

Interface
REQ-001 SHALL have parameter COLS, default 70, characters per line.
REQ-002 SHALL have parameter ROWS, default 30, lines on screen.
REQ-003 SHALL have parameter CHAR_W, default 9, glyph cell width in pixels.
REQ-004 SHALL have parameter CHAR_H, default 16, glyph cell height in pixels.
REQ-005 SHALL have parameter BLINK_CYCLES, default 25000000, cursor half-period in clk cycles.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 key_in  input  8  ASCII code from keyboard path.
REQ-009 p_valid  input  1  key_in valid; accepted when p_valid && p_ready.
REQ-010 p_ready  output  1  block can accept a key this cycle.
REQ-011 x  input  $clog2(COLS)  display-side character column.
REQ-012 y  input  $clog2(ROWS)  display-side character line (logical, 0 = top of screen).
REQ-013 h_addr  input  10  VGA pixel column.
REQ-014 v_addr  input  10  VGA pixel line.
REQ-015 ascii_out  output  8  registered character at (x,y).
REQ-016 row  output  4  registered glyph row = v_addr - y*CHAR_H, low 4 bits.
REQ-017 col  output  4  registered glyph column = h_addr - x*CHAR_W, low 4 bits.
REQ-018 cur_x / cur_y  output  $clog2(COLS) / $clog2(ROWS)  current cursor position (logical).

Function
REQ-019 Storage SHALL be ROWS*COLS bytes; physical address = ((y + top) mod ROWS)*COLS + x, top = scroll offset register.
REQ-020 Read path SHALL have 1-cycle latency for ascii_out, row, col; read of a cell written in the same cycle SHALL return old data.
REQ-021 FSM states SHALL be CLEAR, IDLE, SCROLL; p_ready SHALL be 1 only in IDLE.
REQ-022 CLEAR SHALL write 0x00 to one address per cycle, 0 to ROWS*COLS-1, then go to IDLE.
REQ-023 Accepted 0x0A (ENTER) SHALL set cur_x=0 and perform a line advance; nothing written.
REQ-024 Accepted 0x08 (BS): cur_x>0 -> cur_x-1 and write 0x00 there; cur_x=0,cur_y>0 -> cur_x=COLS-1, cur_y-1, write 0x00 there; at (0,0) SHALL be no-op.
REQ-025 Any other accepted code SHALL be written at the cursor, then cur_x+1; at cur_x=COLS-1 SHALL set cur_x=0 and line advance.
REQ-026 Line advance: cur_y<ROWS-1 -> cur_y+1; cur_y=ROWS-1 -> cur_y unchanged, top = (top+1) mod ROWS, enter SCROLL.
REQ-027 SCROLL SHALL write 0x00 to the COLS cells of the new bottom physical row, one per cycle, then return to IDLE (COLS cycles with p_ready=0).
REQ-028 top wrap from ROWS-1 to 0 SHALL be seamless; display reads during SCROLL SHALL use the updated top.
REQ-029 p_valid while p_ready=0 SHALL be ignored (not queued); sender holds until ready.

Reset
REQ-030 Reset assertion SHALL force state CLEAR, cur_x=0, cur_y=0, top=0, clear counter=0, ascii_out=0, row=0, col=0, p_ready=0, blink phase=0, immediately and regardless of state.
REQ-031 Reset mid-SCROLL or mid-CLEAR SHALL restart CLEAR from address 0 on release; full clear takes ROWS*COLS cycles (2100 default) before p_ready=1.

Configuration
REQ-032 Macro TEXT_VMEM_CURSOR_EN defined: blink counter toggles phase every BLINK_CYCLES; when phase=1 and (x,y)==(cur_x,cur_y), ascii_out SHALL be 0x5F instead of memory data.
REQ-033 Macro undefined: no blink counter; ascii_out SHALL always be memory data.

Verification
REQ-034 Reset, release -> p_ready low exactly 2100 cycles, then high; all cells read 0x00.
REQ-035 Send 'A','B' -> (0,0)=0x41,(1,0)=0x42, cur_x=2; then BS -> (1,0)=0x00, cur_x=1.
REQ-036 Send 70 x 'Z' -> cur_x=0,cur_y=1; 71st 'Z' at (0,1); BS at (0,1) then BS -> cursor (68,0), (69,0)=0x00.
REQ-037 Fill to cur_y=29, send ENTER -> p_ready low 70 cycles, line 0 shows old line 1, line 29 all 0x00, cur_y=29; repeat 30 scrolls -> top wraps to 0.
REQ-038 Assert reset during SCROLL cycle 10 -> outputs 0 at once, full 2100-cycle CLEAR follows, cursor (0,0).
REQ-039 With TEXT_VMEM_CURSOR_EN, BLINK_CYCLES=4, x,y = cursor -> ascii_out alternates 0x5F / cell data every 4 cycles; without macro -> constant cell data.
